// File: rtl/ex_alu_branch_stats_pkg.sv
// Shared execute-stage definitions: datapath width and ALU operation codes.
package cpu_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRA  = 4'd1;
  localparam logic [3:0] ALU_SRL  = 4'd2;
  localparam logic [3:0] ALU_MUL  = 4'd3;
  localparam logic [3:0] ALU_DIV  = 4'd4;
  localparam logic [3:0] ALU_ADD  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_XOR  = 4'd9;
  localparam logic [3:0] ALU_NOR  = 4'd10;
  localparam logic [3:0] ALU_SLT  = 4'd11;
  localparam logic [3:0] ALU_SLTU = 4'd12;

endpackage

// File: rtl/ex_alu_branch_stats_if.sv
// Execute-stage bus: ALU operands/results, branch flags and performance counters.
interface ex_alu_branch_stats_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) ();

  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] y;
  logic [3:0]        alu_op;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] result2;
  logic              equal;
  logic              beq;
  logic              bne;
  logic              bgtz;
  logic [DATA_W-1:0] r1;
  logic              branch_out;
  logic              enable;
  logic              jmp;
  logic [CNT_W-1:0]  count_all;
  logic [CNT_W-1:0]  count_branch;
  logic [CNT_W-1:0]  count_jmp;

  modport master (
    output x, y, alu_op, shamt, beq, bne, bgtz, r1, enable, jmp,
    input  result, result2, equal, branch_out, count_all, count_branch, count_jmp
  );

  modport slave (
    input  x, y, alu_op, shamt, beq, bne, bgtz, r1, enable, jmp,
    output result, result2, equal, branch_out, count_all, count_branch, count_jmp
  );

endinterface

// File: rtl/ex_alu_branch_stats_alu_core.sv
// Purely combinational 32-bit ALU with shifts, signed MUL/DIV and compares.
module alu_core
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  input  logic [3:0]        alu_op_i,
  input  logic [4:0]        shamt_i,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] result2_o
);

  localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]          sra_res;
  logic                       div_zero;
  logic                       div_ovf;
  logic [DATA_W-1:0]          divisor;
  logic signed [DATA_W-1:0]   quot;
  logic signed [DATA_W-1:0]   rem;

  assign prod    = $signed(x_i) * $signed(y_i);
  assign sra_res = $signed(y_i) >>> shamt_i;

  // Dividing by 1 in the overflow case yields exactly quotient INT_MIN, remainder 0,
  // and keeps the divider away from both undefined corners.
  assign div_zero = (y_i == '0);
  assign div_ovf  = (x_i == INT_MIN) && (y_i == '1);
  assign divisor  = (div_zero || div_ovf) ? {{(DATA_W-1){1'b0}}, 1'b1} : y_i;
  assign quot     = $signed(x_i) / $signed(divisor);
  assign rem      = $signed(x_i) % $signed(divisor);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    result_o  = '0;
    result2_o = '0;
    case (alu_op_i)
      ALU_SLL: result_o = y_i << shamt_i;
      ALU_SRA: result_o = sra_res;
      ALU_SRL: result_o = y_i >> shamt_i;
      ALU_MUL: begin
        result_o  = prod[DATA_W-1:0];
        result2_o = prod[2*DATA_W-1:DATA_W];
      end
      ALU_DIV: begin
        if (div_zero) begin
          result_o  = '1;
          result2_o = x_i;
        end else begin
          result_o  = quot;
          result2_o = rem;
        end
      end
      ALU_ADD:  result_o = x_i + y_i;
      ALU_SUB:  result_o = x_i - y_i;
      ALU_AND:  result_o = x_i & y_i;
      ALU_OR:   result_o = x_i | y_i;
      ALU_XOR:  result_o = x_i ^ y_i;
      ALU_NOR:  result_o = ~(x_i | y_i);
      ALU_SLT:  result_o = {{(DATA_W-1){1'b0}}, ($signed(x_i) < $signed(y_i))};
      ALU_SLTU: result_o = {{(DATA_W-1){1'b0}}, (x_i < y_i)};
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_alu_branch_stats.sv
// Execute-stage compute block: ALU, branch decision and cycle/branch/jump counters.
module ex_alu_branch_stats #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int CNT_W  = 32
) (
  input logic                 clk,
  input logic                 clr,
  ex_alu_branch_stats_if.slave bus
);

  logic             branch_taken;
  logic             r1_positive;
  logic [CNT_W-1:0] count_all_q,    count_all_d;
  logic [CNT_W-1:0] count_branch_q, count_branch_d;
  logic [CNT_W-1:0] count_jmp_q,    count_jmp_d;

  alu_core u_alu_core (
    .x_i       (bus.x),
    .y_i       (bus.y),
    .alu_op_i  (bus.alu_op),
    .shamt_i   (bus.shamt),
    .result_o  (bus.result),
    .result2_o (bus.result2)
  );

  assign bus.equal = (bus.x == bus.y);

  // Signed r1 > 0: sign bit clear and not all zero.
  assign r1_positive  = ~bus.r1[DATA_W-1] & (|bus.r1);
  assign branch_taken = (bus.beq & bus.equal) | (bus.bne & ~bus.equal) | (bus.bgtz & r1_positive);
  assign bus.branch_out = branch_taken;

  always_comb begin
    count_all_d    = count_all_q;
    count_branch_d = count_branch_q;
    count_jmp_d    = count_jmp_q;
    if (bus.enable) begin
      count_all_d    = count_all_q + 1'b1;
      count_branch_d = count_branch_q + {{(CNT_W-1){1'b0}}, branch_taken};
      count_jmp_d    = count_jmp_q + {{(CNT_W-1){1'b0}}, bus.jmp};
    end
  end

  // NOTE: clr is sampled on the clock edge only (synchronous), and state uses <= so
  // all three counters update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!clr) begin
      count_all_q    <= '0;
      count_branch_q <= '0;
      count_jmp_q    <= '0;
    end else begin
      count_all_q    <= count_all_d;
      count_branch_q <= count_branch_d;
      count_jmp_q    <= count_jmp_d;
    end
  end

  assign bus.count_all    = count_all_q;
  assign bus.count_branch = count_branch_q;
  assign bus.count_jmp    = count_jmp_q;

endmodule

// File: tb/tb_ex_alu_branch_stats.sv
// Scoreboard bench: directed plan vectors then random cycles against an arithmetic model.
module tb_ex_alu_branch_stats;

  typedef struct {
    logic [31:0] x, y, r1;
    logic [3:0]  op;
    logic [4:0]  sh;
    logic        beq, bne, bgtz, en, jmp, clr;
  } stim_t;

  typedef struct {
    string       name;
    logic [31:0] res, res2, ca, cb, cj;
    logic        eq, br;
  } exp_t;

  logic clk = 1'b0;
  logic clr;
  int   errors = 0;
  int   checks = 0;

  exp_t  sb[$];
  stim_t cur;
  logic [31:0] m_all, m_br, m_j;

  ex_alu_branch_stats_if #(.DATA_W(32), .CNT_W(32)) bus ();

  ex_alu_branch_stats #(.DATA_W(32), .CNT_W(32)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference ALU from the arithmetic definitions, using 64-bit integers.
  function automatic logic [31:0] ref_alu(input stim_t s, output logic [31:0] r2);
    longint xs, ys, xu, yu, p, q, rm;
    logic [63:0] t;
    logic [31:0] r;
    xs = longint'($signed(s.x));
    ys = longint'($signed(s.y));
    xu = longint'({32'd0, s.x});
    yu = longint'({32'd0, s.y});
    p  = longint'(1) << s.sh;
    r  = 32'd0;
    r2 = 32'd0;
    case (s.op)
      4'd0: begin t = 64'(yu * p); r = t[31:0]; end
      4'd1: begin t = 64'((ys - (((ys % p) + p) % p)) / p); r = t[31:0]; end
      4'd2: begin t = 64'(yu / p); r = t[31:0]; end
      4'd3: begin t = 64'(xs * ys); r = t[31:0]; r2 = t[63:32]; end
      4'd4: begin
        if (ys == 0) begin
          r  = 32'hFFFF_FFFF;
          r2 = s.x;
        end else begin
          q = xs / ys;
          rm = xs % ys;
          t = 64'(q);  r  = t[31:0];
          t = 64'(rm); r2 = t[31:0];
        end
      end
      4'd5:  begin t = 64'(xu + yu); r = t[31:0]; end
      4'd6:  begin t = 64'(xu - yu); r = t[31:0]; end
      4'd7:  r = s.x & s.y;
      4'd8:  r = s.x | s.y;
      4'd9:  r = s.x ^ s.y;
      4'd10: r = ~(s.x | s.y);
      4'd11: r = (xs < ys) ? 32'd1 : 32'd0;
      4'd12: r = (xu < yu) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic ref_branch(input stim_t s);
    return (s.beq && s.x == s.y) || (s.bne && s.x != s.y) ||
           (s.bgtz && longint'($signed(s.r1)) > 0);
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.x = 0; s.y = 0; s.r1 = 0; s.op = 4'd15; s.sh = 0;
    s.beq = 0; s.bne = 0; s.bgtz = 0; s.en = 0; s.jmp = 0; s.clr = 1;
    return s;
  endfunction

  function automatic stim_t alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                input logic [4:0] sh);
    stim_t s = idle();
    s.op = op; s.x = x; s.y = y; s.sh = sh;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.x = s.x; bus.y = s.y; bus.r1 = s.r1; bus.alu_op = s.op; bus.shamt = s.sh;
    bus.beq = s.beq; bus.bne = s.bne; bus.bgtz = s.bgtz;
    bus.enable = s.en; bus.jmp = s.jmp; clr = s.clr;
  endtask

  // One cycle: retire the previous inputs into the counter model, then issue new ones.
  task automatic step(input stim_t s, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    if (!cur.clr) begin
      m_all = 0; m_br = 0; m_j = 0;
    end else if (cur.en) begin
      m_all = m_all + 32'd1;
      m_br  = m_br + (ref_branch(cur) ? 32'd1 : 32'd0);
      m_j   = m_j + (cur.jmp ? 32'd1 : 32'd0);
    end
    cur = s;
    drive(s);
    e.name = name;
    e.res  = ref_alu(s, e.res2);
    e.eq   = (s.x == s.y);
    e.br   = ref_branch(s);
    e.ca   = m_all; e.cb = m_br; e.cj = m_j;
    sb.push_back(e);
  endtask

  // Monitor: outputs are stable by the falling edge of the cycle they were issued in.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".result"},       bus.result,  e.res);
        check({e.name, ".result2"},      bus.result2, e.res2);
        check({e.name, ".equal"},        {31'd0, bus.equal},      {31'd0, e.eq});
        check({e.name, ".branch_out"},   {31'd0, bus.branch_out}, {31'd0, e.br});
        check({e.name, ".count_all"},    bus.count_all,    e.ca);
        check({e.name, ".count_branch"}, bus.count_branch, e.cb);
        check({e.name, ".count_jmp"},    bus.count_jmp,    e.cj);
      end
    end
  end

  initial begin
    stim_t s;
    int    drain;
    cur = idle();
    cur.clr = 0;
    drive(cur);
    m_all = 0; m_br = 0; m_j = 0;

    step(idle(), "reset");
    step(alu(4'd5, 32'h7FFF_FFFF, 32'd1, 0), "add_ovf");
    step(alu(4'd6, 32'd0, 32'd1, 0), "sub_wrap");
    step(alu(4'd11, 32'hFFFF_FFFF, 32'd1, 0), "slt");
    step(alu(4'd12, 32'hFFFF_FFFF, 32'd1, 0), "sltu");
    step(alu(4'd1, 0, 32'h8000_0000, 4), "sra");
    step(alu(4'd2, 0, 32'h8000_0000, 4), "srl");
    step(alu(4'd0, 0, 32'h8000_0000, 4), "sll");
    step(alu(4'd10, 0, 0, 0), "nor");
    step(alu(4'd3, 32'hFFFF_FFFE, 32'd3, 0), "mul_neg");
    step(alu(4'd4, 32'hFFFF_FFF9, 32'd2, 0), "div_neg");
    step(alu(4'd4, 32'd5, 32'd0, 0), "div_zero");
    step(alu(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0), "div_ovf");
    step(alu(4'd14, 32'd3, 32'd4, 0), "op_unused");

    s = alu(4'd5, 32'd9, 32'd9, 0); s.beq = 1; step(s, "beq_eq");
    s = alu(4'd5, 32'd9, 32'd9, 0); s.bne = 1; step(s, "bne_eq");
    s = idle(); s.bgtz = 1; s.r1 = 0;            step(s, "bgtz_0");
    s = idle(); s.bgtz = 1; s.r1 = 1;            step(s, "bgtz_1");
    s = idle(); s.bgtz = 1; s.r1 = 32'h8000_0000; step(s, "bgtz_neg");
    s = idle(); s.x = 1; s.y = 2; s.r1 = 5;      step(s, "no_flags");

    // Counters: reset, 10 enabled cycles (3 taken branches, 2 jumps), 5 disabled.
    s = idle(); s.clr = 0; step(s, "cnt_reset");
    for (int i = 0; i < 10; i++) begin
      s = idle(); s.en = 1; s.beq = 1;
      s.x = 1; s.y = (i == 1 || i == 4 || i == 7) ? 32'd1 : 32'd2;
      s.jmp = (i == 2 || i == 5);
      step(s, "cnt_run");
    end
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.bne = 1; s.x = 1; s.y = 2; s.jmp = 1;
      step(s, "cnt_hold");
    end
    step(idle(), "cnt_after_hold");

    // Reset mid-run while branch and jmp are both active, then resume.
    s = idle(); s.en = 1; s.bne = 1; s.x = 1; s.y = 2; s.jmp = 1;
    step(s, "mid_pre");
    s.clr = 0; step(s, "mid_clr");
    s.clr = 1; step(s, "mid_resume");
    step(s, "mid_resume2");

    for (int i = 0; i < 400; i++) begin
      s.x  = $urandom;
      s.y  = $urandom;
      case ($urandom_range(0, 7))
        0: s.y = s.x;
        1: s.y = 0;
        2: s.y = 32'hFFFF_FFFF;
        3: s.x = 32'h8000_0000;
        default: ;
      endcase
      s.r1   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      s.op   = 4'($urandom_range(0, 15));
      s.sh   = 5'($urandom_range(0, 31));
      s.beq  = 1'($urandom_range(0, 1));
      s.bne  = 1'($urandom_range(0, 1));
      s.bgtz = 1'($urandom_range(0, 1));
      s.jmp  = 1'($urandom_range(0, 1));
      s.en   = ($urandom_range(0, 3) != 0);
      s.clr  = ($urandom_range(0, 31) != 0);
      step(s, "rand");
    end
    step(idle(), "final");

    drain = 0;
    while (sb.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
